irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Upstream stage of the 8-input priority encoder.
- Synchronises eight asynchronous interrupt lines and detects their rising edges.
- Holds each event in a pending register and drives the masked pending vector straight into the encoder's 8-bit input.
- Runs a request/acknowledge/end-of-interrupt handshake with the servicing agent, which returns the encoder's 3-bit index as the acknowledge ID.

Parameters:
- SYNC_STAGES, 2, flops per line in the input synchroniser; legal range 2..4.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- irq_in  input  8  raw asynchronous interrupt lines, active high, edge-significant.
- mask  input  8  1 = line masked; a masked line still latches pending but is hidden from pend_vec.
- pend_vec  output  8  pending & ~mask; feeds the priority encoder input.
- irq_req  output  1  interrupt request to the servicing agent.
- ack  input  1  one-cycle acknowledge strobe.
- ack_id  input  3  index being acknowledged (the encoder output).
- eoi  input  1  one-cycle end-of-interrupt strobe.
- busy  output  1  high while an interrupt is in service.
- svc_id  output  3  index currently in service; valid while busy=1.
- lost  output  8  one-cycle pulse per line whose edge arrived while its pending bit was already set.
- ack_err  output  1  one-cycle pulse for an ack with an invalid ack_id.

Behaviour:
- Reset (rst_n=0, asynchronous assert): all synchroniser flops, edge-history flops and pending clear to 0; FSM goes to IDLE.
  - All outputs read 0: pend_vec, irq_req, busy, svc_id, lost, ack_err.
  - Deassertion takes effect on the next clk edge.
  - Reset mid-service discards all pending and in-service state.
- Synchroniser: SYNC_STAGES-deep chain per line, followed by one history flop.
  - edge[i] = sync_out[i] & ~hist[i].
  - A line already high when reset is released counts as a rising edge.
- Pending:
  - pending[i] sets on the clk edge after edge[i].
  - pending[i] clears on a valid ack for id i.
  - Simultaneous set and clear on the same bit: set wins, so the bit stays 1 and the new event is kept.
  - edge[i] while pending[i]=1 (and no clear that cycle): pending stays 1 and lost[i] pulses for one cycle.
- Latency:
  - irq_in[i] first sampled high at clk edge k: pending[i] and pend_vec[i] become high after edge k+SYNC_STAGES.
  - irq_req rises one cycle later.
- pend_vec is combinational from the pending register and mask; mask changes reflect in the same cycle.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: irq_req=0, busy=0. Go to REQ when |pend_vec.
  - REQ: irq_req=1.
    - ack with pend_vec[ack_id]=1: clear pending[ack_id], load svc_id=ack_id, go to SERVICE.
    - ack with pend_vec[ack_id]=0: ack_err pulses, stay in REQ.
    - pend_vec goes to 0 without an ack (masked or reset): go back to IDLE.
  - SERVICE: irq_req=0, busy=1.
    - New edges keep latching into pending.
    - ack here is ignored and pulses ack_err.
    - eoi: go to IDLE; busy drops the next cycle.
    - If pend_vec is nonzero, irq_req reasserts one cycle after IDLE is entered.
- eoi outside SERVICE is ignored with no error.
- ack and eoi together: ack is evaluated against the current state only.
- irq_in must stay high at least SYNC_STAGES+1 clk cycles to be guaranteed captured; shorter pulses may be missed.
- Level held high produces one event only; a new event needs a low phase of at least SYNC_STAGES+1 cycles.

Test Plan:
- Reset/idle: hold rst_n=0 with irq_in=8'hFF, then release. Required: every output is 0 during reset; pend_vec=8'hFF after SYNC_STAGES+1 edges; irq_req=1 on the following edge.
- Basic handshake: irq_in=8'b0110_0011 from idle, mask=0. Required: pend_vec=8'h63, irq_req=1. Then ack with ack_id=6. Required: pend_vec=8'h23, busy=1, svc_id=6, irq_req=0. Then eoi. Required: IDLE, then irq_req=1 again with pend_vec=8'h23.
- Mask: pending=8'h03, mask=8'h03. Required: pend_vec=0, FSM back to IDLE, irq_req=0. Clear mask. Required: pend_vec=8'h03, irq_req=1.
- Invalid ack: pend_vec=8'h01 in REQ, ack with ack_id=5. Required: ack_err pulses once, pending unchanged, still REQ. An ack during SERVICE also pulses ack_err.
- Lost and collision:
  - Second rising edge on line 4 while pending[4]=1. Required: lost=8'h10 for one cycle.
  - Edge on line 2 arriving in the same cycle as a valid ack with ack_id=2. Required: pending[2] stays 1.
- Reset mid-service: assert rst_n=0 while busy=1 and pending=8'h81. Required: busy, svc_id, pend_vec and irq_req go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - synchronised edge-detect pending latch with req/ack/eoi handshake
// Feeds the masked pending vector to the 8-input priority encoder.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_vec,
  output logic       irq_req,
  input  logic       ack,
  input  logic [2:0] ack_id,
  input  logic       eoi,
  output logic       busy,
  output logic [2:0] svc_id,
  output logic [7:0] lost,
  output logic       ack_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [SYNC_STAGES-1:0][7:0]   r_sync;
  logic [7:0]                    r_hist;
  logic [7:0]                    r_pending;
  logic [7:0]                    r_lost;
  logic                          r_ack_err;
  logic [2:0]                    r_svc_id;

  logic [7:0] w_sync_out;
  logic [7:0] w_edge;
  logic       w_ack_ok;
  logic [7:0] w_clr;
  logic [7:0] w_pending_nxt;
  logic [7:0] w_lost_nxt;
  logic       w_ack_err_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_sync_out & ~r_hist;
  assign pend_vec   = r_pending & ~mask;

  // Only an ack in REQ naming a visible pending line is accepted.
  assign w_ack_ok      = (r_state == ST_REQ) && ack && pend_vec[ack_id];
  assign w_clr         = w_ack_ok ? (8'h01 << ack_id) : 8'h00;
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
  assign w_lost_nxt    = w_edge & r_pending & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_hist    <= 8'h00;
      r_pending <= 8'h00;
      r_lost    <= 8'h00;
      r_ack_err <= 1'b0;
      r_svc_id  <= 3'd0;
      r_state   <= ST_IDLE;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_hist    <= w_sync_out;
      r_pending <= w_pending_nxt;
      r_lost    <= w_lost_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_state   <= w_state_nxt;
      if (w_ack_ok) begin
        r_svc_id <= ack_id;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ack) w_ack_err_nxt = 1'b1;
        if (|pend_vec) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ack) begin
          if (pend_vec[ack_id]) w_state_nxt = ST_SERVICE;
          else                  w_ack_err_nxt = 1'b1;
        end else if (pend_vec == 8'h00) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (ack) w_ack_err_nxt = 1'b1;
        if (eoi) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign irq_req = (r_state == ST_REQ);
  assign busy    = (r_state == ST_SERVICE);
  assign svc_id  = r_svc_id;
  assign lost    = r_lost;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed vector bench for irq_pending_latch
module tb_irq_pending_latch;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic       irq_req;
  logic       ack;
  logic [2:0] ack_id;
  logic       eoi;
  logic       busy;
  logic [2:0] svc_id;
  logic [7:0] lost;
  logic       ack_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_pending_latch #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask     (mask),
    .pend_vec (pend_vec),
    .irq_req  (irq_req),
    .ack      (ack),
    .ack_id   (ack_id),
    .eoi      (eoi),
    .busy     (busy),
    .svc_id   (svc_id),
    .lost     (lost),
    .ack_err  (ack_err)
  );

  typedef struct {
    bit         rst;
    logic [7:0] irq;
    logic [7:0] msk;
    logic       ack;
    logic [2:0] aid;
    logic       eoi;
    int         wait_n;
    logic [7:0] e_pend;
    logic       e_req;
    logic       e_busy;
    logic [2:0] e_svc;
    logic [7:0] e_lost;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    irq_in = 8'h00;
    mask   = 8'h00;
    ack    = 1'b0;
    ack_id = 3'd0;
    eoi    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pend_vec"}, pend_vec, 8'h00);
    chk({tag, " irq_req"}, {7'b0, irq_req}, 8'h00);
    chk({tag, " busy"}, {7'b0, busy}, 8'h00);
    chk({tag, " svc_id"}, {5'b0, svc_id}, 8'h00);
    chk({tag, " lost"}, lost, 8'h00);
    chk({tag, " ack_err"}, {7'b0, ack_err}, 8'h00);
  endtask

  initial begin
    // rst irq  msk  ack aid eoi wait | pend req busy svc lost err
    tbl.push_back('{1'b1, 8'h63, 8'h00, 1'b0, 3'd0, 1'b0, 2, 8'h63, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h63, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b1, 3'd6, 1'b0, 0, 8'h23, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b1, 0, 8'h23, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h23, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b1, 3'd2, 1'b0, 0, 8'h23, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h23, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b1, 3'd0, 1'b0, 0, 8'h22, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b1, 3'd1, 1'b0, 0, 8'h22, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b1, 0, 8'h22, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h63, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h22, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    // mask and invalid-ack scenario
    tbl.push_back('{1'b1, 8'h03, 8'h00, 1'b0, 3'd0, 1'b0, 3, 8'h03, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h03, 1'b0, 3'd0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h03, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h02, 1'b0, 3'd0, 1'b0, 0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h02, 1'b1, 3'd5, 1'b0, 0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 8'h03, 8'h02, 1'b1, 3'd1, 1'b0, 0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 8'h03, 8'h02, 1'b0, 3'd0, 1'b0, 0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h02, 1'b1, 3'd0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h02, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 3'd0, 1'b1, 0, 8'h02, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 3'd0, 1'b0, 0, 8'h02, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0});

    // reset with all lines high, then release
    rst_n  = 1'b0;
    irq_in = 8'hFF;
    mask   = 8'h00;
    ack    = 1'b0;
    ack_id = 3'd0;
    eoi    = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    chk("release pend_vec", pend_vec, 8'hFF);
    chk("release irq_req early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("release irq_req", {7'b0, irq_req}, 8'h01);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      irq_in = tbl[i].irq;
      mask   = tbl[i].msk;
      ack    = tbl[i].ack;
      ack_id = tbl[i].aid;
      eoi    = tbl[i].eoi;
      tick();
      ack = 1'b0;
      eoi = 1'b0;
      repeat (tbl[i].wait_n) tick();
      chk($sformatf("v%0d pend_vec", i), pend_vec, tbl[i].e_pend);
      chk($sformatf("v%0d irq_req", i), {7'b0, irq_req}, {7'b0, tbl[i].e_req});
      chk($sformatf("v%0d busy", i), {7'b0, busy}, {7'b0, tbl[i].e_busy});
      chk($sformatf("v%0d lost", i), lost, tbl[i].e_lost);
      chk($sformatf("v%0d ack_err", i), {7'b0, ack_err}, {7'b0, tbl[i].e_err});
      if (tbl[i].e_busy) chk($sformatf("v%0d svc_id", i), {5'b0, svc_id}, {5'b0, tbl[i].e_svc});
    end

    // second rising edge on line 4 while pending[4] is still set
    do_reset();
    irq_in = 8'h10;
    repeat (SYNC_STAGES + 1) tick();
    irq_in = 8'h00;
    repeat (SYNC_STAGES + 1) tick();
    irq_in = 8'h10;
    repeat (SYNC_STAGES) tick();
    chk("lost before", lost, 8'h00);
    tick();
    chk("lost pulse", lost, 8'h10);
    chk("lost pend_vec", pend_vec, 8'h10);
    tick();
    chk("lost cleared", lost, 8'h00);

    // new edge on line 2 in the same cycle as a valid ack for id 2
    do_reset();
    irq_in = 8'h04;
    repeat (SYNC_STAGES + 2) tick();
    chk("coll req", {7'b0, irq_req}, 8'h01);
    irq_in = 8'h00;
    repeat (SYNC_STAGES + 1) tick();
    irq_in = 8'h04;
    repeat (SYNC_STAGES) tick();
    ack    = 1'b1;
    ack_id = 3'd2;
    tick();
    ack = 1'b0;
    chk("coll pend_vec", pend_vec, 8'h04);
    chk("coll busy", {7'b0, busy}, 8'h01);
    chk("coll svc_id", {5'b0, svc_id}, 8'h02);
    chk("coll lost", lost, 8'h00);

    // asynchronous reset while in service with pending 8'h81
    do_reset();
    irq_in = 8'hC1;
    repeat (SYNC_STAGES + 2) tick();
    ack    = 1'b1;
    ack_id = 3'd6;
    tick();
    ack = 1'b0;
    chk("midsvc busy", {7'b0, busy}, 8'h01);
    chk("midsvc pend_vec", pend_vec, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midsvc reset");
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
